// File: rtl/tiny16_pkg.sv
// Shared definitions for the tiny16 display path: transmitter state encoding
// and UART frame geometry.
package tiny16_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;              // start + 8 data + stop
    localparam int WORD_BYTES = 2;               // high byte, then low byte
    localparam int DATA_BITS  = FRAME_BITS - 2;

endpackage

// File: rtl/display_tx_if.sv
// Capture-side bus bundle: the shared data bus and the controller's display strobe.
interface display_tx_if;
    logic [15:0] in;
    logic        dsp_in_en;

    modport master (output in, output dsp_in_en);
    modport slave  (input  in, input  dsp_in_en);
endinterface

// File: rtl/display_tx_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read; push and pop may
// coincide in any state, including full.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/display_tx.sv
// Display strobe sink: queues captured bus words and sends each as two 8N1
// UART bytes, high byte first, on a registered tx line.
module display_tx
    import tiny16_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    display_tx_if.slave  bus,
    output logic         tx,
    output logic         busy,
    output logic         full,
    output logic         overflow
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic [15:0]   hold_reg, hold_next;
    logic          byte_sel_reg, byte_sel_next;
    logic          tx_reg, tx_next;
    logic          overflow_reg, overflow_next;

    logic [15:0]   fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;

    assign pop  = (state_reg == IDLE) && !fifo_empty;
    assign push = bus.dsp_in_en && (!fifo_full || pop);

    sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            hold_reg     <= '0;
            byte_sel_reg <= 1'b0;
            tx_reg       <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            hold_reg     <= hold_next;
            byte_sel_reg <= byte_sel_next;
            tx_reg       <= tx_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        hold_next     = hold_reg;
        byte_sel_next = byte_sel_reg;
        tx_next       = 1'b1;
        overflow_next = overflow_reg | (bus.dsp_in_en && fifo_full && !pop);

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    hold_next     = fifo_dout;
                    shift_next    = fifo_dout[15:8];
                    byte_sel_next = 1'b0;
                    cnt_next      = '0;
                    state_next    = START;
                end
            end
            START: begin
                if (cnt_reg == CNT_MAX) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (cnt_reg == CNT_MAX) begin
                    cnt_next = '0;
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = STOP;
                    end else begin
                        shift_next   = shift_reg >> 1;
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            STOP: begin
                if (cnt_reg == CNT_MAX) begin
                    cnt_next = '0;
                    // Low byte follows the high byte back-to-back.
                    if (!byte_sel_reg) begin
                        shift_next    = hold_reg[7:0];
                        byte_sel_next = 1'b1;
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // tx is registered from the state being entered, so it changes on the transition edge.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    assign tx       = tx_reg;
    assign busy     = (state_reg != IDLE) || !fifo_empty;
    assign full     = fifo_full;
    assign overflow = overflow_reg;
endmodule

// File: doc/display_tx.md
# display_tx

Output-side responder for the controller's display strobe. While `dsp_in_en` is high, the block captures the 16-bit bus word and queues it in a small FIFO. It then serializes each word as two 8N1 UART bytes on `tx`, high byte first. It sits beside memory and the register file on the shared bus. It is purely a sink: it never drives the bus.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clocks per UART bit; legal range 2..65535.
- `FIFO_DEPTH`, 4: word entries; power of two, at least 2.

Ports:
- `clk`  in  1  system clock; every state change is on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `in`  in  16  shared data bus.
- `dsp_in_en`  in  1  capture strobe from the controller; high for one clock per OUT instruction.
- `tx`  out  1  UART serial output; idles high.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `full`  out  1  FIFO holds `FIFO_DEPTH` words.
- `overflow`  out  1  sticky; set when a strobe is dropped; cleared only by `rst`.

## Operation
- **Capture:** on a rising edge with `dsp_in_en`=1, push `in` into the FIFO.
  - If the FIFO is full and no pop occurs in the same cycle, drop the word and set `overflow`.
  - If the FIFO is full and a pop occurs in the same cycle, accept the push; the count is unchanged.
- **FSM states:** IDLE, START, DATA, STOP, plus a 1-bit `byte_sel` (0 = high byte, 1 = low byte).
- **IDLE:**
  - With the FIFO non-empty: pop the head word into a 16-bit holding register, load `hold[15:8]` into the shift register, set `byte_sel`=0, and go to START.
  - Otherwise: stay in IDLE with `tx`=1.
- **START:** `tx`=0 for `CLKS_PER_BIT` clocks, then go to DATA.
- **DATA:** shift 8 bits out LSB-first, each held for `CLKS_PER_BIT` clocks, then go to STOP.
- **STOP:** `tx`=1 for `CLKS_PER_BIT` clocks, then:
  - if `byte_sel`=0: load `hold[7:0]`, set `byte_sel`=1, and go directly to START with no idle gap;
  - else: go to IDLE.
- **Counters:**
  - Bit-time counter is `clog2(CLKS_PER_BIT)` bits wide; it runs 0..`CLKS_PER_BIT`-1 and resets on every state change.
  - Bit index runs 0..7.
  - FIFO pointers are `clog2(FIFO_DEPTH)` bits and wrap naturally.
  - Count is `clog2(FIFO_DEPTH)`+1 bits.
- **Reset values:** `tx`=1, `busy`=0, `full`=0, `overflow`=0, FSM in IDLE, FIFO empty.
- **Reset mid-frame:** the frame is aborted, `tx` returns to 1 on the next edge, and queued words are discarded.
- `in` is ignored whenever `dsp_in_en`=0, including while `rst`=1.

## Timing
- `tx` is a registered output; there is no combinational path from inputs to any output.
- Push at edge N with the FIFO empty and the FSM in IDLE:
  - the pop happens at edge N+1;
  - `tx` falls after edge N+1.
- One byte takes `10*CLKS_PER_BIT` clocks; one word takes `20*CLKS_PER_BIT` clocks.
- STOP of the low byte is followed by exactly one IDLE clock before the next word's start bit.
- `busy` rises after the push edge and falls after the edge that returns the FSM to IDLE with the FIFO empty.
- `full` and `overflow` update on the same edge as the push or pop that causes them.
- Strobes may arrive on consecutive clocks; each one is evaluated independently.

## Structure
- Shared package/header `tiny16_pkg`: FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the frame length constants (10 bits per byte, 2 bytes per word).
- One sub-module, `sync_fifo`, parameterized by `WIDTH` and `DEPTH`:
  - ports: `push`, `pop`, `din`, `dout`, `full`, `empty`;
  - `dout` shows the head word (first-word fall-through);
  - same-cycle push and pop are legal in every state.
- `display_tx` holds the FSM, the bit timer, the shift/holding registers and the `overflow` flag.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
1. **Reset values:** hold `rst` for 3 clocks → `tx`=1, `busy`=0, `full`=0, `overflow`=0.
2. **Single word:** one strobe with `in`=16'h4142 → frame 0x41 then 0x42.
   - Bit sequence is 0,1000 0010,1 then 0,0100 0010,1.
   - Each bit lasts 4 clocks; 80 clocks in total, with no gap between the two bytes.
   - `busy` falls 1 clock after the final stop bit.
3. **Overflow:** strobes on 6 consecutive clocks with `in`=1..6 →
   - word 1 is popped at the second edge, so words 2–5 fill the FIFO;
   - word 6 is dropped and `overflow`=1;
   - `tx` carries 0x00,0x01 through 0x00,0x05 with one idle clock between words.
4. **Full plus pop:** fill the FIFO, then strobe on the exact edge the FSM pops → the word is accepted, `full` stays 1, and `overflow` stays 0.
5. **Reset mid-frame:** assert `rst` during a DATA bit of 16'hA55A with 2 words queued → `tx`=1 on the next edge, `busy`=0, and nothing further is transmitted.
6. **Strobe low:** toggle `in` randomly for 100 clocks with `dsp_in_en`=0 → `tx` stays 1 and `busy` stays 0.
